// File: rtl/tmds_sequencer.sv
// TMDS line sequencer: control / preamble / guard / video timing.
// Drives encoder strobes, ping-pong serializer loads and symbol select.
module tmds_sequencer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int LINE_PIXELS  = 640
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       line_start,
  output logic       pixel_req,
  output logic       D2_load,
  output logic       S1_load,
  output logic       S2_load,
  output logic       L2_load,
  output logic       D1_load,
  output logic       SR0_load,
  output logic       SR1_load,
  output logic       shiftmuxsel,
  output logic [1:0] out_sel,
  output logic       s_rst,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    CTRL,
    PRE,
    GUARD,
    VIDEO
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [10:0] cnt;
  logic [10:0] nxt_cnt;
  logic [1:0]  nxt_sel;
  logic        last;
  logic        stage1;

  assign last = (cnt == 11'd0);

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      CTRL: begin
        if (line_start) begin
          nxt_state = PRE;
          nxt_cnt   = 11'(PREAMBLE_LEN - 1);
        end
      end
      PRE: begin
        if (last) begin
          nxt_state = GUARD;
          nxt_cnt   = 11'(GUARD_LEN - 1);
        end else begin
          nxt_cnt = cnt - 11'd1;
        end
      end
      GUARD: begin
        if (last) begin
          nxt_state = VIDEO;
          nxt_cnt   = 11'(LINE_PIXELS - 1);
        end else begin
          nxt_cnt = cnt - 11'd1;
        end
      end
      VIDEO: begin
        if (last) begin
          nxt_state = CTRL;
        end else begin
          nxt_cnt = cnt - 11'd1;
        end
      end
      default: begin
        nxt_state = CTRL;
        nxt_cnt   = 11'd0;
      end
    endcase
  end

  always_comb begin
    nxt_sel = 2'b00;
    case (nxt_state)
      PRE:     nxt_sel = 2'b01;
      GUARD:   nxt_sel = 2'b11;
      VIDEO:   nxt_sel = 2'b10;
      default: nxt_sel = 2'b00;
    endcase
  end

  // Stage-1 runs two symbols ahead of VIDEO to cover encoder latency.
  assign stage1 =
    (nxt_state == GUARD && nxt_cnt <= 11'd1) ||
    (nxt_state == VIDEO && nxt_cnt >= 11'd2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= CTRL;
      cnt         <= 11'd0;
      pixel_req   <= 1'b0;
      D2_load     <= 1'b0;
      S1_load     <= 1'b0;
      S2_load     <= 1'b0;
      L2_load     <= 1'b0;
      D1_load     <= 1'b0;
      SR0_load    <= 1'b0;
      SR1_load    <= 1'b0;
      shiftmuxsel <= 1'b0;
      out_sel     <= 2'b00;
      s_rst       <= 1'b1;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      pixel_req   <= stage1;
      D2_load     <= stage1;
      S1_load     <= stage1;
      S2_load     <= stage1;
      L2_load     <= stage1;
      D1_load     <= pixel_req;
      // SR0 leads after reset, then the pair ping-pongs.
      SR0_load    <= ~SR0_load;
      SR1_load    <= SR0_load;
      shiftmuxsel <= SR1_load;
      out_sel     <= nxt_sel;
      s_rst       <= (nxt_state == CTRL);
      busy        <= (nxt_state != CTRL);
      overrun     <= line_start && (state != CTRL);
    end
  end

endmodule
